shift_pipe: RTL and testbench

- Parametrised, pipelined barrel shifter for the execute datapath.
- One log2 stage per pipeline register: stage k shifts or rotates by 2^k when count bit k is set.
- Supports rotate-left, shift-left, rotate-right and arithmetic shift-right.
- Valid/ready handshake on both sides; one result per cycle when not stalled.

---
 rtl/shift_pipe.sv | 86 ++++++++
 tb/tb_shift_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: one log2 shift/rotate step per registered stage.
// A single global stall holds the whole pipe when the output is blocked.
module shift_pipe #(
  parameter int WIDTH = 16,
  localparam int STAGES = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [STAGES-1:0] in_cnt,
  input  logic [1:0]        in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [STAGES:0]   occupancy
);

  localparam logic [STAGES:0] ONE = 1;

  logic [STAGES-1:0]             v;
  logic [STAGES-1:0][WIDTH-1:0]  d;
  logic [STAGES-1:0][1:0]        o;
  logic [STAGES-1:0][STAGES-1:0] c;
  logic advance;
  logic in_xfer;
  logic out_xfer;
  logic unused_bits;

  function automatic logic [WIDTH-1:0] xf(
    input logic [WIDTH-1:0] x,
    input logic [1:0]       op,
    input int               s
  );
    logic [WIDTH-1:0] r;
    r = x;
    case (op)
      2'b00:   r = (x << s) | (x >> (WIDTH - s));
      2'b01:   r = x << s;
      2'b10:   r = (x >> s) | (x << (WIDTH - s));
      default: r = $signed(x) >>> s;
    endcase
    return r;
  endfunction

  assign advance   = out_ready | ~out_valid;
  assign in_ready  = advance;
  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];
  assign in_xfer   = in_valid & advance;
  assign out_xfer  = out_valid & out_ready;

  // Later stages only consult their own count bit; the rest ride along.
  assign unused_bits = ^c ^ ^o[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      d <= '0;
      o <= '0;
      c <= '0;
    end else if (advance) begin
      v    <= {v[STAGES-2:0], in_valid};
      d[0] <= in_cnt[0] ? xf(in_data, in_op, 1) : in_data;
      o[0] <= in_op;
      c[0] <= in_cnt;
      for (int k = 1; k < STAGES; k++) begin
        d[k] <= c[k-1][k] ? xf(d[k-1], o[k-1], 1 << k) : d[k-1];
        o[k] <= o[k-1];
        c[k] <= c[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy <= occupancy + ONE;
    end else if (out_xfer && !in_xfer) begin
      occupancy <= occupancy - ONE;
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe at WIDTH=16.
// Inputs change and outputs are sampled on the falling edge.
module tb_shift_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_cnt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [4:0]  occupancy;

  int checks = 0;
  int errors = 0;

  shift_pipe #(.WIDTH(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_cnt(in_cnt),
    .in_op(in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .occupancy(occupancy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic drain();
    in_valid  = 0;
    out_ready = 1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 0;
    in_valid  = 0;
    in_data   = 0;
    in_cnt    = 0;
    in_op     = 0;
    out_ready = 1;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid);
    end
    checks++;
    if (out_data !== 16'h0000) begin
      errors++; $display("FAIL reset_out_data got %h exp 0000", out_data);
    end
    checks++;
    if (occupancy !== 5'd0) begin
      errors++; $display("FAIL reset_occupancy got %0d exp 0", occupancy);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic single(
    input logic [1:0]  op,
    input logic [15:0] dat,
    input logic [3:0]  cnt,
    input logic [15:0] exp,
    input string       nm
  );
    int lat;
    lat = 0;
    @(negedge clk);
    in_valid = 1;
    in_op    = op;
    in_data  = dat;
    in_cnt   = cnt;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      in_valid = 0;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat != 4) begin
      errors++; $display("FAIL %s_latency got %0d exp 4", nm, lat);
    end
    checks++;
    if (out_data !== exp) begin
      errors++; $display("FAIL %s_data got %h exp %h", nm, out_data, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_ops();
    single(2'b00, 16'h8001, 4'd1,  16'h0003, "rol_8001_1");
    single(2'b01, 16'h8001, 4'd4,  16'h0010, "sll_8001_4");
    single(2'b10, 16'h0001, 4'd1,  16'h8000, "ror_0001_1");
    single(2'b11, 16'h8000, 4'd15, 16'hFFFF, "sra_8000_15");
    single(2'b11, 16'h7FFF, 4'd15, 16'h0000, "sra_7fff_15");
    single(2'b00, 16'h1234, 4'd15, 16'h091A, "rol_1234_15");
    single(2'b10, 16'h1234, 4'd8,  16'h3412, "ror_1234_8");
    single(2'b11, 16'hC000, 4'd3,  16'hF800, "sra_c000_3");
    single(2'b00, 16'hA5A5, 4'd0,  16'hA5A5, "rol_cnt0");
    single(2'b01, 16'hA5A5, 4'd0,  16'hA5A5, "sll_cnt0");
    single(2'b10, 16'hA5A5, 4'd0,  16'hA5A5, "ror_cnt0");
    single(2'b11, 16'hA5A5, 4'd0,  16'hA5A5, "sra_cnt0");
  endtask

  task automatic test_back_to_back();
    int acc;
    int done;
    int occ_exp;
    drain();
    for (int t = 0; t < 14; t++) begin
      if (t > 0) @(negedge clk);
      acc     = (t < 8) ? t : 8;
      done    = (t - 4 < 0) ? 0 : ((t - 4 > 8) ? 8 : t - 4);
      occ_exp = acc - done;
      checks++;
      if (occupancy !== 5'(occ_exp)) begin
        errors++; $display("FAIL b2b_occ t%0d got %0d exp %0d", t, occupancy, occ_exp);
      end
      checks++;
      if (out_valid !== (t >= 4 && t < 12)) begin
        errors++; $display("FAIL b2b_valid t%0d got %b", t, out_valid);
      end
      if (t >= 4 && t < 12) begin
        checks++;
        if (out_data !== (16'h0001 << (t - 4))) begin
          errors++;
          $display("FAIL b2b_data t%0d got %h exp %h", t, out_data, 16'h0001 << (t - 4));
        end
      end
      in_valid = (t < 8);
      in_op    = 2'b01;
      in_data  = 16'h0001;
      in_cnt   = 4'(t);
    end
    in_valid = 0;
  endtask

  task automatic test_backpressure();
    logic [15:0] got[$];
    drain();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      in_op    = 2'b01;
      in_data  = 16'h0001;
      in_cnt   = 4'(i + 1);
      @(negedge clk);
    end
    in_cnt    = 4'd5;
    out_ready = 0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_in_ready_comb got %b exp 0", in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold_hs c%0d rdy %b vld %b", i, in_ready, out_valid);
      end
      checks++;
      if (out_data !== 16'h0002) begin
        errors++; $display("FAIL bp_hold_data c%0d got %h exp 0002", i, out_data);
      end
      checks++;
      if (occupancy !== 5'd4) begin
        errors++; $display("FAIL bp_hold_occ c%0d got %0d exp 4", i, occupancy);
      end
    end
    out_ready = 1;
    if (out_valid) got.push_back(out_data);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = 0;
      if (out_valid) got.push_back(out_data);
    end
    checks++;
    if (got.size() != 5) begin
      errors++; $display("FAIL bp_count got %0d exp 5", got.size());
    end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== (16'h0002 << i)) begin
        errors++; $display("FAIL bp_order i%0d got %h exp %h", i, got[i], 16'h0002 << i);
      end
    end
  endtask

  task automatic test_bubbles();
    drain();
    for (int t = 0; t < 13; t++) begin
      if (t > 0) @(negedge clk);
      if (t >= 4 && t < 12) begin
        checks++;
        if (out_valid !== ((t - 4) % 2 == 0)) begin
          errors++; $display("FAIL bubble_valid t%0d got %b", t, out_valid);
        end
        if ((t - 4) % 2 == 0) begin
          checks++;
          if (out_data !== 16'(16'h0100 + (t - 4))) begin
            errors++; $display("FAIL bubble_data t%0d got %h", t, out_data);
          end
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL bubble_idle t%0d got %b exp 0", t, out_valid);
        end
      end
      in_valid = (t < 8) && (t % 2 == 0);
      in_op    = 2'b00;
      in_cnt   = 4'd0;
      in_data  = 16'(16'h0100 + t);
    end
    in_valid = 0;
  endtask

  task automatic test_reset_midflight();
    drain();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      in_op    = 2'b10;
      in_data  = 16'h00F0;
      in_cnt   = 4'(i);
      @(negedge clk);
    end
    in_valid = 0;
    checks++;
    if (occupancy !== 5'd3) begin
      errors++; $display("FAIL rst_pre_occ got %0d exp 3", occupancy);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (occupancy !== 5'd0 || out_valid !== 1'b0 || out_data !== 16'h0000) begin
      errors++;
      $display("FAIL rst_async occ %0d vld %b data %h exp 0/0/0000", occupancy, out_valid, out_data);
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 5'd0) begin
        errors++; $display("FAIL rst_post c%0d vld %b occ %0d exp 0/0", i, out_valid, occupancy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_backpressure();
    test_bubbles();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
